// File: rtl/decoder_scan.sv
// decoder_scan: registered 1-of-N line decoder with direct select and an
// auto-scan mode that dwells on each channel, then blanks for one cycle
// before moving to the next channel.
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_mode,
  input  logic                    i_opt,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [SEL_W-1:0]        i_last,
  input  logic [DIV_W-1:0]        i_div,
  output logic [(2**SEL_W)-1:0]   o_y,
  output logic [SEL_W-1:0]        o_idx,
  output logic                    o_valid,
  output logic                    o_wrap
);

  localparam int OUT_N = 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    HOLD,
    BLANK
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   idx_q;
  logic [OUT_N-1:0]   y_q;
  logic               valid_q;
  logic               wrap_q;

  logic [SEL_W-1:0]   idx_d;
  logic               wrap_d;
  logic [OUT_N-1:0]   y_off;

  // Selected line at level opt, all others at ~opt.
  function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] idx,
                                              input logic             opt);
    logic [OUT_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return opt ? oh : ~oh;
  endfunction

  // Next scan channel: wrap to 0 at or beyond the last channel (also covers
  // i_last being lowered below the current index mid-scan).
  always_comb begin
    idx_d  = '0;
    wrap_d = 1'b0;
    if (idx_q >= i_last) begin
      idx_d  = '0;
      wrap_d = 1'b1;
    end else begin
      idx_d  = idx_q + SEL_W'(1);
    end
  end

  assign y_off = {OUT_N{~i_opt}};

  // Mode FSM with all outputs registered; o_y is re-evaluated every cycle so
  // a polarity change lands on the next edge in every state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= y_off;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!i_en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= y_off;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!i_mode) begin
      // Direct decode from any state; scan position is discarded.
      state_q <= DIRECT;
      cnt_q   <= '0;
      idx_q   <= i_sel;
      y_q     <= decode(i_sel, i_opt);
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DIRECT: begin
          state_q <= HOLD;
          cnt_q   <= '0;
          idx_q   <= '0;
          y_q     <= decode('0, i_opt);
          valid_q <= 1'b1;
          wrap_q  <= 1'b0;
        end
        HOLD: begin
          wrap_q <= 1'b0;
          // >= so a live i_div lowered below the count ends the dwell at once.
          if (cnt_q >= i_div) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            y_q     <= y_off;
            valid_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + DIV_W'(1);
            y_q     <= decode(idx_q, i_opt);
            valid_q <= 1'b1;
          end
        end
        BLANK: begin
          state_q <= HOLD;
          cnt_q   <= '0;
          idx_q   <= idx_d;
          y_q     <= decode(idx_d, i_opt);
          valid_q <= 1'b1;
          wrap_q  <= wrap_d;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          y_q     <= y_off;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_y     = y_q;
  assign o_idx   = idx_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (SEL_W=3, DIV_W=16).
module tb_decoder_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        opt;
  logic [2:0]  sel;
  logic [2:0]  last;
  logic [15:0] div;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        valid;
  logic        wrap;

  int checks = 0;
  int errs   = 0;

  logic [7:0] scan_y   [13] = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00,
                                8'h04, 8'h04, 8'h04, 8'h00, 8'h01, 8'h01};
  logic [2:0] scan_idx [13] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
  logic       scan_w   [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] ch_y     [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder_scan #(.SEL_W(3), .DIV_W(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_mode (mode),
    .i_opt  (opt),
    .i_sel  (sel),
    .i_last (last),
    .i_div  (div),
    .o_y    (y),
    .o_idx  (idx),
    .o_valid(valid),
    .o_wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                         input logic ev, input logic ew);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".idx"}, 32'(idx), 32'(ei));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; opt = 1'b0;
    sel = 3'd0; last = 3'd0; div = 16'd0;

    // Reset, active-low polarity
    tick();
    chk_all("reset", 8'hFF, 3'd0, 1'b0, 1'b0);

    // Direct decode and polarity flip
    rst = 1'b0; en = 1'b1; sel = 3'd5;
    tick();
    chk_all("direct5_lo", 8'hDF, 3'd5, 1'b1, 1'b0);
    opt = 1'b1;
    tick();
    chk_all("direct5_hi", 8'h20, 3'd5, 1'b1, 1'b0);
    sel = 3'd0;
    tick();
    chk_all("direct0_hi", 8'h01, 3'd0, 1'b1, 1'b0);

    // Scan i_div=2, i_last=2
    div = 16'd2; last = 3'd2; mode = 1'b1;
    tick();
    chk_all("scan_entry", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk_all($sformatf("scan%0d", i), scan_y[i], scan_idx[i], scan_y[i] != 8'h00, scan_w[i]);
    end

    // i_div=0: one HOLD + one BLANK per channel, run up to channel 6
    div = 16'd0; last = 3'd7;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("d0_blank%0d", k), 8'h00, 3'(k - 1), 1'b0, 1'b0);
      tick();
      chk_all($sformatf("d0_hold%0d", k), ch_y[k], 3'(k), 1'b1, 1'b0);
    end

    // i_last lowered below current index: wrap at next advance
    last = 3'd3;
    tick();
    chk_all("lower_blank", 8'h00, 3'd6, 1'b0, 1'b0);
    tick();
    chk_all("lower_wrap", 8'h01, 3'd0, 1'b1, 1'b1);

    // Live i_div lowered below the running count ends the dwell
    div = 16'd5;
    tick(); chk_all("div5_c1", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); chk_all("div5_c2", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); chk_all("div5_c3", 8'h01, 3'd0, 1'b1, 1'b0);
    div = 16'd1;
    tick(); chk_all("div_drop_blank", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk_all("div_drop_next", 8'h02, 3'd1, 1'b1, 1'b0);

    // Enable dropped during HOLD, then re-enabled: full dwell at channel 0
    en = 1'b0;
    tick(); chk_all("en_off", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_all("en_on_c0", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); chk_all("en_on_c1", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); chk_all("en_on_blank", 8'h00, 3'd0, 1'b0, 1'b0);

    // Polarity change mid-HOLD and in BLANK
    tick(); chk_all("opt_hold_hi", 8'h02, 3'd1, 1'b1, 1'b0);
    opt = 1'b0;
    tick(); chk_all("opt_hold_lo", 8'hFD, 3'd1, 1'b1, 1'b0);
    tick(); chk_all("opt_blank_lo", 8'hFF, 3'd1, 1'b0, 1'b0);

    // Reset mid-BLANK with active-high polarity
    opt = 1'b1; rst = 1'b1;
    tick(); chk_all("rst_blank", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_all("rst_restart", 8'h01, 3'd0, 1'b1, 1'b0);

    // Leave scan for direct mode
    mode = 1'b0; sel = 3'd3;
    tick(); chk_all("scan_to_direct", 8'h08, 3'd3, 1'b1, 1'b0);

    // i_last=0: channel 0 only, wrap on every advance
    mode = 1'b1; last = 3'd0; div = 16'd0;
    tick(); chk_all("l0_entry", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); chk_all("l0_blank1", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk_all("l0_hold1", 8'h01, 3'd0, 1'b1, 1'b1);
    tick(); chk_all("l0_blank2", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk_all("l0_hold2", 8'h01, 3'd0, 1'b1, 1'b1);

    // Polarity tracked while idle
    en = 1'b0; opt = 1'b0;
    tick(); chk_all("idle_lo", 8'hFF, 3'd0, 1'b0, 1'b0);
    opt = 1'b1;
    tick(); chk_all("idle_hi", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, the select width; legal range 1..6.
REQ-002 The block SHALL have parameter DIV_W, default 16, the dwell-counter width.
REQ-003 The block SHALL derive localparam OUT_N = 2**SEL_W, the number of output lines.
REQ-004 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_en  in  1  block enable; 0 forces all outputs inactive.
REQ-007 i_mode  in  1  0 = direct decode of i_sel; 1 = auto-scan.
REQ-008 i_opt  in  1  polarity; 0 = active-low outputs (selected line 0, others 1); 1 = active-high.
REQ-009 i_sel  in  SEL_W  channel select used in direct mode.
REQ-010 i_last  in  SEL_W  highest channel visited in scan mode.
REQ-011 i_div  in  DIV_W  scan dwell; each channel is held for i_div+1 cycles.
REQ-012 o_y  out  OUT_N  registered one-hot decode, with polarity set by i_opt.
REQ-013 o_idx  out  SEL_W  registered index of the currently driven channel.
REQ-014 o_valid  out  1  1 when exactly one o_y line is active.
REQ-015 o_wrap  out  1  one-cycle pulse when scan advances from i_last to 0.

Function
REQ-016 The FSM SHALL have four states: IDLE, DIRECT, HOLD, BLANK.
REQ-017 Inactive level SHALL be defined as: all o_y bits equal ~i_opt, o_valid=0.
REQ-018 Active level SHALL be defined as: o_y bit k equals i_opt when k == index, and ~i_opt otherwise.
REQ-019 IDLE SHALL be entered whenever i_en=0, from any state, on the next edge.
- In IDLE: o_y inactive, dwell counter = 0, o_idx = 0.
REQ-020 IDLE transitions on the next edge with i_en=1:
- to DIRECT if i_mode=0;
- to HOLD with o_idx=0 and counter=0 if i_mode=1.
REQ-021 DIRECT SHALL register the decode of i_sel into o_y and i_sel into o_idx every cycle, with 1-cycle latency.
REQ-022 In DIRECT, i_mode=1 SHALL move the FSM to HOLD with index 0 and counter 0.
REQ-023 In HOLD, the counter SHALL increment each cycle; when counter == i_div, the FSM SHALL go to BLANK and clear the counter.
REQ-024 In BLANK (exactly one cycle), o_y SHALL be inactive (anti-ghosting); the FSM then goes to HOLD with the index advanced.
REQ-025 Index advance rule: if o_idx >= i_last, next index is 0 and o_wrap pulses with the first HOLD cycle of channel 0; otherwise next index is o_idx+1.
REQ-026 i_last=0 SHALL scan channel 0 only, with o_wrap pulsing on every advance.
REQ-027 If i_last is lowered below o_idx mid-scan, the index SHALL wrap to 0 at the next advance.
REQ-028 i_div=0 SHALL give a 1-cycle HOLD followed by a 1-cycle BLANK per channel.
REQ-029 In HOLD or BLANK, i_mode=0 SHALL move the FSM to DIRECT on the next edge and abandon the scan position.
REQ-030 An i_opt change SHALL take effect on o_y at the next edge, in every state, without disturbing FSM state or counter.
REQ-031 The counter compare SHALL use the live i_div; if counter > i_div after a change, the compare SHALL be treated as met.
REQ-032 o_wrap SHALL be 0 in all cycles other than those defined in REQ-025.

Reset
REQ-033 With i_rst=1 at an edge, the block SHALL set:
- FSM = IDLE, counter = 0, o_idx = 0, o_valid = 0, o_wrap = 0;
- o_y = inactive level for the i_opt sampled at that edge.
REQ-034 Reset SHALL override i_en, i_mode and any in-progress scan; the first non-reset edge follows REQ-020.

Verification
REQ-035 Reset with i_opt=0, SEL_W=3 -> o_y=8'hFF, o_idx=0, o_valid=0, o_wrap=0.
REQ-036 Direct mode, i_opt=0, i_sel=5 -> one edge later o_y=8'hDF; then i_opt=1 -> next edge o_y=8'h20.
REQ-037 Scan mode, i_div=2, i_last=2, i_opt=1 -> repeating pattern: 01 x3, 00, 02 x3, 00, 04 x3, 00, 01; o_wrap high on the first 01 cycle after 04.
REQ-038 Scan at o_idx=6, i_last set to 3 -> after BLANK, o_idx=0 and o_wrap=1.
REQ-039 i_en dropped during HOLD -> next edge: o_y inactive, o_idx=0; re-enable restarts the scan at channel 0 with a full dwell.
REQ-040 Reset asserted mid-BLANK with i_opt=1 -> o_y=8'h00; the scan restarts from index 0 after release.
